// File: rtl/isram_read_responder.sv
// isram_read_responder: read-only AXI-lite-style responder that models the instruction SRAM.
// It answers one outstanding read at a time: an AR handshake is followed by a fixed latency
// and then a single registered R beat. A side preload port writes words into the array at any time.
//
// Optional feature (compile-time macro ISRAM_RAND_LAT_EN): adds 0..7 cycles of pseudo-random
// latency from an 8-bit LFSR on every request. Without the macro the latency is exactly LAT.
//
// Parameters:
//   DATA_WIDTH  width of address and data
//   DEPTH_LOG2  log2 of the array depth in words
//   BASE_ADDR   byte address of word 0
//   LAT         extra wait cycles between AR handshake and rvalid (0..255)
//
// Ports:
//   clk, rst                  clock (rising edge) and asynchronous active-high reset
//   isram_araddr/arvalid      read request (byte address, valid)
//   isram_arready             responder can accept AR
//   isram_rdata/rresp/rvalid  read response (data, 00 OKAY / 10 SLVERR / 11 DECERR, valid)
//   isram_rready              master accepts R
//   ld_we/ld_addr/ld_data     preload write port (word index)

module isram_read_responder #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH_LOG2 = 10,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned           LAT        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] isram_araddr,
  input  logic                  isram_arvalid,
  output logic                  isram_arready,
  output logic [DATA_WIDTH-1:0] isram_rdata,
  output logic                  isram_rvalid,
  output logic [1:0]            isram_rresp,
  input  logic                  isram_rready,
  input  logic                  ld_we,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data
);

  localparam int unsigned           Words    = 1 << DEPTH_LOG2;
  localparam logic [DATA_WIDTH-1:0] MemBytes = DATA_WIDTH'(4 * Words);
  // Wide enough for LAT (<=255) plus the optional random extra (<=7).
  localparam int unsigned           CntW     = 9;
  localparam logic [CntW-1:0]       LatCnt   = CntW'(LAT);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StWaitLat,
    StResp
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;

  logic [DATA_WIDTH-1:0]   mem_q [Words];

  logic [CntW-1:0]         lat_load;
  logic [DATA_WIDTH-1:0]   off;
  logic [DEPTH_LOG2-1:0]   word_idx;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [1:0]              rd_resp;

  // ---------------------------------------------------------------------------
  // Latency source
  // ---------------------------------------------------------------------------
`ifdef ISRAM_RAND_LAT_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR, taps 8,6,5,4; free-running so the extra wait varies per request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign lat_load = LatCnt + CntW'(lfsr_q[2:0]);
`else
  assign lat_load = LatCnt;
`endif

  // ---------------------------------------------------------------------------
  // Word array (not reset; contents come only from the preload port)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode of the latched request
  // ---------------------------------------------------------------------------
  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign off      = addr_q - BASE_ADDR;
  assign word_idx = off[DEPTH_LOG2+1:2];

  always_comb begin
    rd_data = '0;
    rd_resp = RespOkay;
    if (off >= MemBytes) begin
      rd_resp = RespDecerr;
    end else if (addr_q[1:0] != 2'b00) begin
      rd_resp = RespSlverr;
    end else begin
      rd_data = mem_q[word_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    unique case (state_q)
      StIdle: begin
        arready_d = 1'b1;
        if (isram_arvalid && arready_q) begin
          addr_d    = isram_araddr;
          arready_d = 1'b0;
          cnt_d     = lat_load;
          state_d   = (lat_load == '0) ? StResp : StWaitLat;
        end
      end

      StWaitLat: begin
        if (cnt_q <= CntW'(1)) begin
          cnt_d   = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StResp: begin
        // The first cycle in RESP (rvalid still low) is the array-read cycle: the word
        // is sampled here, so a preload write on this same edge is not seen.
        if (!rvalid_q) begin
          rvalid_d = 1'b1;
          rdata_d  = rd_data;
          rresp_d  = rd_resp;
        end else if (isram_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          state_d   = StIdle;
        end
      end

      default: begin
        state_d   = StIdle;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign isram_arready = arready_q;
  assign isram_rvalid  = rvalid_q;
  assign isram_rdata   = rdata_q;
  assign isram_rresp   = rresp_q;

endmodule
